// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lcd_pkg
// Brief   : Shared constants, state encoding and address stepping for the
//           character-LCD bus monitor.
// Revision: 1.0 - initial release
// ============================================================================
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } lcd_state_e;

  localparam logic [7:0] c_space = 8'h20;

  // Opcodes are matched in this order: the highest set bit wins.
  localparam logic [7:0] c_cmd_set_dd_mask = 8'h80;
  localparam logic [7:0] c_cmd_set_dd      = 8'h80;
  localparam logic [7:0] c_cmd_set_cg_mask = 8'hC0;
  localparam logic [7:0] c_cmd_set_cg      = 8'h40;
  localparam logic [7:0] c_cmd_nop_min     = 8'h08;
  localparam logic [7:0] c_cmd_entry_mask  = 8'hFC;
  localparam logic [7:0] c_cmd_entry       = 8'h04;
  localparam logic [7:0] c_cmd_home_mask   = 8'hFE;
  localparam logic [7:0] c_cmd_home        = 8'h02;
  localparam logic [7:0] c_cmd_clear       = 8'h01;

  localparam logic [6:0] c_row0_base = 7'h00;
  localparam logic [6:0] c_row1_base = 7'h40;
  localparam logic [6:0] c_row0_last = 7'h27;
  localparam logic [6:0] c_row1_last = 7'h67;

  function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (addr == c_row0_last)      nxt = c_row1_base;
      else if (addr == c_row1_last) nxt = c_row0_base;
      else                          nxt = addr + 7'd1;
    end else begin
      if (addr == c_row0_base)      nxt = c_row1_last;
      else if (addr == c_row1_base) nxt = c_row0_last;
      else                          nxt = addr - 7'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_if.sv
`default_nettype none
// ============================================================================
// Module  : lcd_bus_if
// Brief   : 4-bit character-LCD write bus as driven by the display driver.
// Revision: 1.0 - initial release
// ============================================================================
interface lcd_bus_if;
  logic       lcd_sf_e;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_d;

  modport master (output lcd_sf_e, lcd_e, lcd_rs, lcd_rw, lcd_d);
  modport slave  (input  lcd_sf_e, lcd_e, lcd_rs, lcd_rw, lcd_d);
endinterface
`default_nettype wire

// File: rtl/lcd_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module  : lcd_strobe_sync
// Brief   : Synchronises the LCD bus and flags falling edges of e, with the
//           other fields taken from the same pipeline stage as e.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  lcd_bus_if.slave        bus,
  output logic            strobe,
  output logic            s_sf_e,
  output logic            s_rw,
  output logic            s_rs,
  output logic [3:0]      s_d
);

  // Each stage carries {sf_e, rw, rs, d[3:0], e} so all fields stay aligned.
  logic [SYNC_STAGES-1:0][7:0] r_pipe;
  logic                        r_e_last;
  logic [7:0]                  w_in;
  logic [7:0]                  w_out;

  assign w_in  = {bus.lcd_sf_e, bus.lcd_rw, bus.lcd_rs, bus.lcd_d, bus.lcd_e};
  assign w_out = r_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe   <= '0;
      r_e_last <= 1'b0;
    end else begin
      r_pipe   <= {r_pipe[SYNC_STAGES-2:0], w_in};
      r_e_last <= w_out[0];
    end
  end

  assign strobe = r_e_last & ~w_out[0];
  assign {s_sf_e, s_rw, s_rs, s_d} = w_out[7:1];

endmodule
`default_nettype wire

// File: rtl/lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module  : lcd_bus_monitor
// Brief   : Passive 4-bit LCD bus receiver: byte reassembly, command decode,
//           DDRAM address tracking and a 2-row shadow character buffer.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_bus_monitor
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int ROW_LEN        = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  lcd_bus_if.slave        bus,
  output logic            byte_valid,
  output logic [7:0]      byte_data,
  output logic            byte_rs,
  output logic [6:0]      cur_addr,
  input  wire logic [4:0] rd_idx,
  output logic [7:0]      rd_char,
  output logic            nibble_err
);

  localparam int               c_tw        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tw-1:0]  c_timer_max = c_tw'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]       c_row_len   = 7'(ROW_LEN);

  lcd_state_e       r_state, w_state_nx;
  logic [3:0]       r_hi;
  logic             r_rs_hi;
  logic [c_tw-1:0]  r_timer;
  logic             r_inc;
  logic             r_cg;
  logic [7:0]       r_buf [2*ROW_LEN];

  logic             w_strobe, w_sf_e, w_rw, w_rs, w_acc;
  logic [3:0]       w_d;
  logic             w_done, w_err;
  logic [7:0]       w_byte;
  logic             w_vis0, w_vis1;
  logic [4:0]       w_idx;

  lcd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .strobe (w_strobe),
    .s_sf_e (w_sf_e),
    .s_rw   (w_rw),
    .s_rs   (w_rs),
    .s_d    (w_d)
  );

  assign w_acc  = w_strobe & w_sf_e & ~w_rw;
  assign w_byte = {r_hi, w_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      ST_INIT: if (w_acc) begin
        if (w_d == 4'h2)      w_state_nx = ST_HIGH;
        else if (w_d != 4'h3) w_err      = 1'b1;
      end
      ST_HIGH: if (w_acc) w_state_nx = ST_LOW;
      ST_LOW: begin
        if (w_acc) begin
          w_state_nx = ST_HIGH;
          if (w_rs == r_rs_hi) w_done = 1'b1;
          else                 w_err  = 1'b1;
        end else if (r_timer == c_timer_max) begin
          w_state_nx = ST_HIGH;
          w_err      = 1'b1;
        end
      end
      default: w_state_nx = ST_INIT;
    endcase
  end

  // Timer only runs while waiting for the low nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= 4'h0;
      r_rs_hi <= 1'b0;
      r_timer <= '0;
    end else if (r_state == ST_HIGH && w_acc) begin
      r_hi    <= w_d;
      r_rs_hi <= w_rs;
      r_timer <= '0;
    end else if (r_state == ST_LOW && !w_acc && r_timer != c_timer_max) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_vis0 = (cur_addr < c_row_len);
  assign w_vis1 = (cur_addr >= c_row1_base) && (cur_addr < c_row1_base + c_row_len);
  assign w_idx  = w_vis0 ? cur_addr[4:0] : 5'(c_row_len) + 5'(cur_addr - c_row1_base);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_rs    <= 1'b0;
      nibble_err <= 1'b0;
      rd_char    <= 8'h00;
      cur_addr   <= c_row0_base;
      r_inc      <= 1'b1;
      r_cg       <= 1'b0;
      for (int i = 0; i < 2*ROW_LEN; i++) r_buf[i] <= c_space;
    end else begin
      byte_valid <= w_done;
      nibble_err <= w_err;
      rd_char    <= r_buf[rd_idx];
      if (w_done) begin
        byte_data <= w_byte;
        byte_rs   <= r_rs_hi;
        if (!r_rs_hi) begin
          if ((w_byte & c_cmd_set_dd_mask) == c_cmd_set_dd) begin
            cur_addr <= w_byte[6:0];
            r_cg     <= 1'b0;
          end else if ((w_byte & c_cmd_set_cg_mask) == c_cmd_set_cg) begin
            r_cg <= 1'b1;
          end else if (w_byte >= c_cmd_nop_min) begin
            r_cg <= r_cg;
          end else if ((w_byte & c_cmd_entry_mask) == c_cmd_entry) begin
            r_inc <= w_byte[1];
          end else if ((w_byte & c_cmd_home_mask) == c_cmd_home) begin
            cur_addr <= c_row0_base;
            r_cg     <= 1'b0;
          end else if (w_byte == c_cmd_clear) begin
            cur_addr <= c_row0_base;
            r_inc    <= 1'b1;
            r_cg     <= 1'b0;
            for (int i = 0; i < 2*ROW_LEN; i++) r_buf[i] <= c_space;
          end
        end else if (!r_cg) begin
          // Off-screen addresses still advance the counter.
          if (w_vis0 || w_vis1) r_buf[w_idx] <= w_byte;
          cur_addr <= step_addr(cur_addr, r_inc);
        end
      end
    end
  end

endmodule
`default_nettype wire
